// File: rtl/tt_equiv_sweeper.sv
// tt_equiv_sweeper
// Walks every input combination through two boolean implementations that share
// one input bus. For each vector it records the reference output and compares it
// with the simplified output. At the end of the sweep it reports the mismatch
// count, the first failing vector and a pass flag.
module tt_equiv_sweeper #(
    parameter int N_INPUTS      = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       ref_out,
    input  logic                       dut_out,
    output logic [N_INPUTS-1:0]        vec,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N_INPUTS:0]          mismatch_count,
    output logic [N_INPUTS-1:0]        first_fail,
    output logic                       first_fail_valid,
    output logic [(1<<N_INPUTS)-1:0]   tt_ref
);

    localparam int NVEC  = 1 << N_INPUTS;
    // The counter must hold SETTLE_CYCLES; two extra states keep the width >= 1.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);

    localparam logic [N_INPUTS-1:0] LAST_VEC    = N_INPUTS'(NVEC - 1);
    localparam logic [N_INPUTS-1:0] VEC_ONE     = N_INPUTS'(1);
    localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam bit                  NO_SETTLE   = (SETTLE_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 mismatch;
    logic [N_INPUTS:0]    count_next;

    // Per-vector compare result and the count that includes the current sample.
    // The count cannot wrap because the mismatch_count width holds 2^N_INPUTS.
    always_comb begin
        mismatch   = ref_out ^ dut_out;
        count_next = mismatch_count + {{N_INPUTS{1'b0}}, mismatch};
    end

    // Sweep sequencer. All outputs are registered. Results persist in IDLE
    // until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            tt_ref           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mismatch_count   <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                        tt_ref           <= '0;
                        pass             <= 1'b0;
                        vec              <= '0;
                        settle_cnt       <= SETTLE_LOAD;
                        busy             <= 1'b1;
                        state            <= NO_SETTLE ? SAMPLE : HOLD;
                    end
                end

                HOLD: begin
                    // vec is held here for SETTLE_CYCLES cycles. The sample
                    // cycle adds one more.
                    if (settle_cnt <= CNT_ONE) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_ONE;
                    end
                end

                SAMPLE: begin
                    tt_ref[vec]    <= ref_out;
                    mismatch_count <= count_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail       <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    if (vec == LAST_VEC) begin
                        // Compute pass from the count that includes the last
                        // sample, so it is already valid while done is high.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (count_next == '0);
                        state <= DONE;
                    end else begin
                        vec        <= vec + VEC_ONE;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= NO_SETTLE ? SAMPLE : HOLD;
                    end
                end

                DONE: begin
                    // start is ignored here. A held start re-triggers from IDLE.
                    done  <= 1'b0;
                    pass  <= (mismatch_count == '0);
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tt_equiv_sweeper.md
# tt_equiv_sweeper

Sequencer that exhaustively sweeps all 2^N_INPUTS input combinations into two combinational boolean implementations: a canonical sum-of-minterms form and a hand-simplified grouping form. It compares their outputs per vector, captures the reference truth table, and reports mismatch count, first failing vector and pass/fail. It sits between the lab's start switch/status LEDs and the pair of functions under comparison, and owns their shared input bus.

## Interface
- N_INPUTS, 5, number of function inputs; vector bit N_INPUTS-1 drives `a` (MSB), bit 0 drives the last input (`e` for N=5)
- SETTLE_CYCLES, 1, extra cycles each vector is held before sampling; 0 is legal

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse or level; sampled only in IDLE
- ref_out  in  1  output of canonical implementation
- dut_out  in  1  output of simplified implementation
- vec  out  N_INPUTS  shared input vector to both implementations
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse after final vector sampled
- pass  out  1  high when last completed sweep had zero mismatches
- mismatch_count  out  N_INPUTS+1  mismatches in current/last sweep
- first_fail  out  N_INPUTS  lowest vector index that mismatched
- first_fail_valid  out  1  first_fail holds a real index
- tt_ref  out  2^N_INPUTS  captured ref_out truth table, bit i = ref_out at vec=i

## Operation
- FSM states: IDLE, HOLD, SAMPLE, DONE.
- IDLE: busy=0. On start=1: clear mismatch_count, first_fail, first_fail_valid, tt_ref, pass; vec<=0; settle counter<=SETTLE_CYCLES; go HOLD (or SAMPLE directly if SETTLE_CYCLES=0).
- HOLD: vec stable; decrement settle counter; go SAMPLE when it reaches 1.
- SAMPLE: tt_ref[vec]<=ref_out; if ref_out!=dut_out: mismatch_count+=1, and if !first_fail_valid: first_fail<=vec, first_fail_valid<=1. If vec==2^N_INPUTS-1 go DONE; else vec<=vec+1, reload settle counter, go HOLD (or stay SAMPLE if SETTLE_CYCLES=0).
- DONE: done=1 for exactly this cycle; pass<=(mismatch_count==0) using the final count including the last sample; go IDLE.
- Results (pass, mismatch_count, first_fail*, tt_ref, vec) hold in IDLE until the next accepted start.
- start while busy or in DONE is ignored; no queuing.
- mismatch_count never wraps: max value 2^N_INPUTS fits in N_INPUTS+1 bits.
- vec does not wrap: after the last vector it stays at 2^N_INPUTS-1.

## Timing
- Reset values: vec=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail=0, first_fail_valid=0, tt_ref=0, state IDLE.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronous); no partial results retained.
- busy rises the cycle after start is sampled; falls in the same edge done rises.
- Each vector is driven for exactly SETTLE_CYCLES+1 cycles; ref_out/dut_out are sampled at the rising edge ending the last of those cycles.
- Sweep length: 2^N_INPUTS*(SETTLE_CYCLES+1) cycles of busy, then one done cycle. Default: 64 busy cycles, done in cycle 65 after start.
- pass, mismatch_count and tt_ref are final and stable when done=1.
- Back-to-back: start high continuously re-triggers one cycle after DONE (IDLE visited for one cycle).

## Test plan
- ref_out and dut_out tied to the same function with minterms {0,1,2,3,4,5,6,8,9,10,11,12,15,19,22,23,24,25,26,27,30,31}, defaults -> done 65 cycles after start, pass=1, mismatch_count=0, first_fail_valid=0, tt_ref=0xCFC89F7F.
- dut_out = ~ref_out -> mismatch_count=32, first_fail=0, first_fail_valid=1, pass=0.
- dut_out differs from ref_out only at vec=13 and vec=29 -> mismatch_count=2, first_fail=13, pass=0.
- SETTLE_CYCLES=0, identical functions -> busy exactly 32 cycles, vec increments every cycle 0..31, pass=1.
- rst_n low while vec=10 mid-sweep, then release and start -> all outputs at reset values during reset; new sweep starts at vec=0 with counts cleared.
- start pulsed at vec=7 during a sweep -> ignored, sweep completes normally with a single done pulse and unchanged results.
